// File: rtl/int_issue_pkg.sv
// Shared types and constants for the integer operand issue stage.
//   fwd_src_t    : where a resolved operand came from (or that it must stall)
//   PEND_W_DFLT  : default width of one scoreboard counter
//   PEND_MAX     : largest in-flight write count at the default width
//   pend_max()   : largest in-flight write count for an arbitrary width
`ifndef XLEN
`define XLEN 32
`endif

package int_issue_pkg;

   localparam int PEND_W_DFLT = 2;
   localparam int PEND_MAX    = 2**PEND_W_DFLT - 1;

   typedef enum logic [2:0] {
      FWD_ZERO,
      FWD_RF,
      FWD_EXEC,
      FWD_WB,
      FWD_STALL
   } fwd_src_t;

   function automatic int pend_max(input int w);
      return 2**w - 1;
   endfunction

endpackage

// File: rtl/int_operand_issue_bypass_sel.sv
// operand_bypass_sel: resolves one source operand from x0, the exec bypass,
// the writeback bypass or the register file, or reports that it must stall.
// Ports:
//   idx                         source register index
//   pend                        scoreboard count for idx
//   out_valid/out_rd_write/out_rd  instruction currently held in the issue register
//   exec_fwd_*                  result leaving exec this cycle
//   wb_*                        result being written back this cycle
//   rf_data                     register file read data for idx
//   data/ready/src              resolved value, usable flag, chosen source
module operand_bypass_sel
   import int_issue_pkg::*;
#(
   parameter int XLEN   = `XLEN,
   parameter int PEND_W = PEND_W_DFLT
) (
   input  logic [4:0]        idx,
   input  logic [PEND_W-1:0] pend,
   input  logic              out_valid,
   input  logic              out_rd_write,
   input  logic [4:0]        out_rd,
   input  logic              exec_fwd_valid,
   input  logic [4:0]        exec_fwd_rd,
   input  logic [XLEN-1:0]   exec_fwd_data,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic [XLEN-1:0]   rf_data,
   output logic [XLEN-1:0]   data,
   output logic              ready,
   output fwd_src_t          src
);

   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   always_comb begin
      data  = '0;
      ready = 1'b0;
      src   = FWD_STALL;
      if (idx == 5'd0) begin
         ready = 1'b1;
         src   = FWD_ZERO;
      end else if (out_valid && out_rd_write && out_rd == idx) begin
         // Producer is still waiting in our own output register; its
         // result exists nowhere yet.
         src = FWD_STALL;
      end else if (exec_fwd_valid && exec_fwd_rd == idx) begin
         data  = exec_fwd_data;
         ready = 1'b1;
         src   = FWD_EXEC;
      end else if (pend == PEND_ONE && wb_valid && wb_rd == idx) begin
         // Only safe when the writeback is the sole outstanding producer;
         // with more in flight a younger value is still coming.
         data  = wb_data;
         ready = 1'b1;
         src   = FWD_WB;
      end else if (pend == '0) begin
         data  = rf_data;
         ready = 1'b1;
         src   = FWD_RF;
      end
   end

endmodule

// File: rtl/int_operand_issue.sv
// int_operand_issue: register-read / issue stage in front of the integer unit.
// Reads rs1/rs2, bypasses exec and writeback results, tracks outstanding
// destination writes in a per-register counter, and hands operands to exec
// through a registered valid/ready output.
// Ports:
//   clk, rst                    clock, async active-high reset
//   flush                       drop the output register and clear the scoreboard
//   in_*                        decoded instruction handshake and fields
//   rf_rs*_sel / rf_rs*_data    register file read port (same-cycle data)
//   exec_fwd_*                  exec result bypass
//   wb_*                        writeback bypass and scoreboard release
//   out_*                       registered operands to exec
module int_operand_issue
   import int_issue_pkg::*;
#(
   parameter int XLEN      = `XLEN,
   parameter int PAYLOAD_W = 64,
   parameter int PEND_W    = PEND_W_DFLT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [4:0]           in_rd,
   input  logic                 in_rd_write,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic [4:0]           rf_rs1_sel,
   output logic [4:0]           rf_rs2_sel,
   input  logic [XLEN-1:0]      rf_rs1_data,
   input  logic [XLEN-1:0]      rf_rs2_data,
   input  logic                 exec_fwd_valid,
   input  logic [4:0]           exec_fwd_rd,
   input  logic [XLEN-1:0]      exec_fwd_data,
   input  logic                 wb_valid,
   input  logic [4:0]           wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_rs1_data,
   output logic [XLEN-1:0]      out_rs2_data,
   output logic [4:0]           out_rd,
   output logic                 out_rd_write,
   output logic [PAYLOAD_W-1:0] out_payload
);

   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(pend_max(PEND_W));

   logic [PEND_W-1:0] pend [32];

   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            rs1_ready, rs2_ready;
   fwd_src_t        rs1_src, rs2_src;
   logic            rd_full;
   logic            issue;
   logic            inc, dec;

   assign rf_rs1_sel = in_rs1;
   assign rf_rs2_sel = in_rs2;

   operand_bypass_sel #(.XLEN(XLEN), .PEND_W(PEND_W)) u_rs1_sel (
      .idx            (in_rs1),
      .pend           (pend[in_rs1]),
      .out_valid      (out_valid),
      .out_rd_write   (out_rd_write),
      .out_rd         (out_rd),
      .exec_fwd_valid (exec_fwd_valid),
      .exec_fwd_rd    (exec_fwd_rd),
      .exec_fwd_data  (exec_fwd_data),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .rf_data        (rf_rs1_data),
      .data           (rs1_data),
      .ready          (rs1_ready),
      .src            (rs1_src)
   );

   operand_bypass_sel #(.XLEN(XLEN), .PEND_W(PEND_W)) u_rs2_sel (
      .idx            (in_rs2),
      .pend           (pend[in_rs2]),
      .out_valid      (out_valid),
      .out_rd_write   (out_rd_write),
      .out_rd         (out_rd),
      .exec_fwd_valid (exec_fwd_valid),
      .exec_fwd_rd    (exec_fwd_rd),
      .exec_fwd_data  (exec_fwd_data),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .rf_data        (rf_rs2_data),
      .data           (rs2_data),
      .ready          (rs2_ready),
      .src            (rs2_src)
   );

   // A counter at its ceiling cannot take another producer; holding the
   // instruction here is cheaper than widening every counter.
   assign rd_full  = in_rd_write && (in_rd != 5'd0) && (pend[in_rd] == PEND_FULL);
   assign in_ready = !rst && !flush && (!out_valid || out_ready)
                     && rs1_ready && rs2_ready && !rd_full;
   assign issue    = in_valid && in_ready;

   assign inc = issue && in_rd_write && (in_rd != 5'd0);
   assign dec = wb_valid && (wb_rd != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '{default: '0};
      end else if (flush) begin
         pend <= '{default: '0};
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (inc && in_rd == 5'(i) && !(dec && wb_rd == 5'(i))) begin
               pend[i] <= pend[i] + PEND_ONE;
            end else if (dec && wb_rd == 5'(i) && !(inc && in_rd == 5'(i))
                         && pend[i] != '0) begin
               pend[i] <= pend[i] - PEND_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
         out_rd       <= '0;
         out_rd_write <= 1'b0;
         out_payload  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (issue) begin
         out_valid    <= 1'b1;
         out_rs1_data <= rs1_data;
         out_rs2_data <= rs2_data;
         out_rd       <= in_rd;
         out_rd_write <= in_rd_write;
         out_payload  <= in_payload;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // A writeback against a register with nothing outstanding means the
   // upstream bookkeeping has gone wrong.
   a_no_dec_at_zero : assert property (@(posedge clk) disable iff (rst)
      !(dec && !flush && pend[wb_rd] == '0));

   a_src_matches_ready : assert property (@(posedge clk) disable iff (rst)
      (rs1_ready == (rs1_src != FWD_STALL)) && (rs2_ready == (rs2_src != FWD_STALL)));

endmodule

// File: tb/tb_int_operand_issue.sv
module tb_int_operand_issue;
   import int_issue_pkg::*;

   localparam int XLEN = 32;
   localparam int PW   = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid, in_ready;
   logic [4:0]      in_rs1, in_rs2, in_rd;
   logic            in_rd_write;
   logic [PW-1:0]   in_payload;
   logic [4:0]      rf_rs1_sel, rf_rs2_sel;
   logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
   logic            exec_fwd_valid;
   logic [4:0]      exec_fwd_rd;
   logic [XLEN-1:0] exec_fwd_data;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            out_valid, out_ready;
   logic [XLEN-1:0] out_rs1_data, out_rs2_data;
   logic [4:0]      out_rd;
   logic            out_rd_write;
   logic [PW-1:0]   out_payload;

   int n_cmp = 0;
   int n_bad = 0;
   int pl_cnt = 0;

   typedef struct packed {
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [4:0]      rd;
      logic            wr;
      logic [PW-1:0]   pl;
   } exp_t;

   exp_t expq[$];

   always #5 clk = ~clk;

   int_operand_issue #(.XLEN(XLEN), .PAYLOAD_W(PW), .PEND_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rd_write(in_rd_write), .in_payload(in_payload),
      .rf_rs1_sel(rf_rs1_sel), .rf_rs2_sel(rf_rs2_sel),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .exec_fwd_valid(exec_fwd_valid), .exec_fwd_rd(exec_fwd_rd),
      .exec_fwd_data(exec_fwd_data),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_rd(out_rd), .out_rd_write(out_rd_write), .out_payload(out_payload)
   );

   // Register file model: x0 deliberately holds junk so operand-0 handling is visible.
   logic [XLEN-1:0] rf [32];
   assign rf_rs1_data = rf[rf_rs1_sel];
   assign rf_rs2_data = rf[rf_rs2_sel];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + 32'(i);
         rf[0] <= 32'hBAD0_0000;
         rf[3] <= 32'h0;
      end else if (wb_valid && wb_rd != 5'd0) begin
         rf[wb_rd] <= wb_data;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every transfer to exec against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         n_cmp++;
         if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL out_unexpected: got rs1=%0h rs2=%0h rd=%0d pl=%0h with nothing expected",
                     out_rs1_data, out_rs2_data, out_rd, out_payload);
         end else begin
            e = expq.pop_front();
            if ({out_rs1_data, out_rs2_data, out_rd, out_rd_write, out_payload} !== e) begin
               n_bad++;
               $display("FAIL out_xfer: got rs1=%0h rs2=%0h rd=%0d wr=%0b pl=%0h expected rs1=%0h rs2=%0h rd=%0d wr=%0b pl=%0h",
                        out_rs1_data, out_rs2_data, out_rd, out_rd_write, out_payload,
                        e.rs1, e.rs2, e.rd, e.wr, e.pl);
            end
         end
      end
   end

   task automatic idle();
      flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
      in_rd_write = 1'b0; in_payload = '0;
      exec_fwd_valid = 1'b0; exec_fwd_rd = '0; exec_fwd_data = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
   endtask

   task automatic instr(input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic wr);
      in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_write = wr;
      in_payload = {32'hC0DE_0000, 32'(pl_cnt)};
      pl_cnt++;
   endtask

   task automatic exec_fwd(input logic [4:0] rd, input logic [XLEN-1:0] d);
      exec_fwd_valid = 1'b1; exec_fwd_rd = rd; exec_fwd_data = d;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
      wb_valid = 1'b1; wb_rd = rd; wb_data = d;
   endtask

   task automatic sample(input string name, input bit exp_rdy,
                         input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
      exp_t e;
      chk(name, 64'(in_ready), 64'(exp_rdy));
      if (in_valid && exp_rdy) begin
         e.rs1 = e1; e.rs2 = e2; e.rd = in_rd; e.wr = in_rd_write; e.pl = in_payload;
         expq.push_back(e);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string name, input bit exp_rdy,
                       input logic [XLEN-1:0] e1 = '0, input logic [XLEN-1:0] e2 = '0);
      @(negedge clk);
      sample(name, exp_rdy, e1, e2);
      adv();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t dropped;
      idle();
      rst = 1'b1;
      instr(5'd1, 5'd2, 5'd3, 1'b1);
      @(negedge clk);
      chk("rst_out_valid",   64'(out_valid), 64'd0);
      chk("rst_in_ready",    64'(in_ready), 64'd0);
      chk("rst_out_rs1",     64'(out_rs1_data), 64'd0);
      chk("rst_out_payload", out_payload, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle();
      adv();

      // exec bypass for a dependent instruction presented alongside its producer's result
      idle(); exec_fwd(5'd1, 32'hFFFF_FFFF); instr(5'd1, 5'd0, 5'd2, 1'b1);
      step("t1_exec_fwd", 1, 32'hFFFF_FFFF, 32'h0);
      idle(); wb(5'd2, 32'h5);
      step("t1_wb", 1);

      // producer held in the output register blocks its consumer
      idle(); instr(5'd0, 5'd0, 5'd5, 1'b1);
      step("t2_prod", 1, 0, 0);
      idle(); out_ready = 1'b0; instr(5'd5, 5'd0, 5'd0, 1'b0);
      step("t2_hold", 0);
      idle(); instr(5'd5, 5'd0, 5'd0, 1'b0);
      step("t2_in_outreg", 0);
      idle(); exec_fwd(5'd5, 32'h55); instr(5'd5, 5'd0, 5'd0, 1'b0);
      step("t2_exec", 1, 32'h55, 32'h0);
      idle(); wb(5'd5, 32'h55);
      step("t2_wb", 1);

      // writeback bypass while the register file is still stale
      idle(); instr(5'd0, 5'd0, 5'd3, 1'b1);
      step("t3_prod", 1, 0, 0);
      idle();
      step("t3_gap", 1);
      idle(); wb(5'd3, 32'h1234); instr(5'd3, 5'd3, 5'd0, 1'b0);
      step("t3_wb_fwd", 1, 32'h1234, 32'h1234);
      idle(); instr(5'd3, 5'd0, 5'd0, 1'b0);
      step("t3_rf_after", 1, 32'h1234, 32'h0);

      // two producers of x7: older writeback must not be forwarded
      idle(); instr(5'd0, 5'd0, 5'd7, 1'b1);
      step("t4_p1", 1, 0, 0);
      idle(); instr(5'd0, 5'd0, 5'd7, 1'b1);
      step("t4_p2", 1, 0, 0);
      idle();
      step("t4_gap", 1);
      idle(); wb(5'd7, 32'hAA); instr(5'd7, 5'd0, 5'd0, 1'b0);
      step("t4_wb_pend2", 0);
      idle(); instr(5'd7, 5'd0, 5'd0, 1'b0);
      step("t4_wait", 0);
      idle(); exec_fwd(5'd7, 32'h77); instr(5'd7, 5'd0, 5'd0, 1'b0);
      step("t4_exec", 1, 32'h77, 32'h0);
      idle(); wb(5'd7, 32'h77);
      step("t4_wb2", 1);

      // scoreboard counter saturation on x9
      for (int k = 0; k < 3; k++) begin
         idle(); instr(5'd0, 5'd0, 5'd9, 1'b1);
         step("t5_fill", 1, 0, 0);
      end
      idle(); instr(5'd0, 5'd0, 5'd9, 1'b1);
      step("t5_full", 0);
      idle(); wb(5'd9, 32'h99); instr(5'd0, 5'd0, 5'd9, 1'b1);
      step("t5_full_wb", 0);
      idle(); instr(5'd0, 5'd0, 5'd9, 1'b1);
      step("t5_after_wb", 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         idle(); wb(5'd9, 32'h99);
         step("t5_drain", 1);
      end

      // x0 ignores every bypass and the register file
      idle(); exec_fwd(5'd0, 32'hDEAD); wb(5'd0, 32'hBEEF); instr(5'd0, 5'd0, 5'd0, 1'b0);
      step("t6_x0", 1, 0, 0);

      // flush with a live output register and pend[4]=2
      idle(); instr(5'd0, 5'd0, 5'd4, 1'b1);
      step("t7_a", 1, 0, 0);
      idle(); instr(5'd0, 5'd0, 5'd4, 1'b1);
      step("t7_b", 1, 0, 0);
      idle(); out_ready = 1'b0; flush = 1'b1; instr(5'd4, 5'd0, 5'd0, 1'b0);
      step("t7_flush", 0);
      dropped = expq.pop_back();
      idle(); instr(5'd4, 5'd0, 5'd0, 1'b0);
      @(negedge clk);
      chk("t7_out_valid_cleared", 64'(out_valid), 64'd0);
      sample("t7_pend_cleared", 1, 32'h1000_0004, 32'h0);
      adv();

      // asynchronous reset while an instruction sits in the output register
      idle(); instr(5'd0, 5'd0, 5'd0, 1'b0);
      step("t8_issue", 1, 0, 0);
      idle();
      #1 rst = 1'b1;
      #1;
      chk("t8_rst_out_valid", 64'(out_valid), 64'd0);
      chk("t8_rst_payload",   out_payload, 64'd0);
      dropped = expq.pop_back();
      instr(5'd0, 5'd0, 5'd6, 1'b0);
      @(negedge clk);
      sample("t8_rst_in_ready", 0, 0, 0);
      adv();
      rst = 1'b0;
      idle(); instr(5'd0, 5'd0, 5'd6, 1'b0);
      step("t8_post", 1, 0, 0);
      idle();
      step("drain1", 1);
      step("drain2", 1);

      chk("queue_empty", 64'(expq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
